gearbox_16x2_tx: RTL

- Transmit-side counterpart of the 2-bit-write / 16-bit-read capture buffer.
- Accepts 16-bit words from pixel/control logic and emits them as a stream of 2-bit pairs, one pair per enabled cycle.
- A small register FIFO sits in front of a shift register, so words can arrive bursty while the serial side is paced by out_enable.
- Default pair order is LSB-first (pair k = bits [2k+1:2k]), matching the capture buffer's word packing.

---
 rtl/gearbox_16x2_tx_pkg.sv | 24 ++
 rtl/sync_fifo_reg.sv | 74 +++++++
 rtl/gearbox_16x2_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/gearbox_16x2_tx_pkg.sv
// Shared definitions for the 16-bit to 2-bit transmit gearbox.
//   GB_WORD_W  : width of a parallel word
//   GB_PAIR_W  : width of one serial symbol (a bit pair)
//   GB_PAIRS   : pairs per word
//   gb_phase_t : index of the pair currently presented
//   gb_pair_offset : bit offset of pair k inside a word, for either emit order
package gearbox_16x2_tx_pkg;

    localparam int GB_WORD_W = 16;
    localparam int GB_PAIR_W = 2;
    localparam int GB_PAIRS  = 8;

    typedef logic [2:0] gb_phase_t;

    // LSB-first: pair k lives at bits [2k+1:2k].
    // MSB-first: pair k lives at bits [15-2k:14-2k].
    function automatic int gb_pair_offset(input gb_phase_t k, input bit msb_first);
        if (msb_first) begin
            return (GB_PAIRS - 1 - int'(k)) * GB_PAIR_W;
        end
        return int'(k) * GB_PAIR_W;
    endfunction

endpackage

// File: rtl/sync_fifo_reg.sv
// Small register-based synchronous FIFO with a registered occupancy count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en/wr_data: push (ignored when full)
//   rd_en/rd_data: pop (ignored when empty); rd_data shows the head entry
//   count        : entries held, registered
//   empty, full  : decoded from count
//   wr_ready     : registered "count will be below DEPTH", low while in reset
module sync_fifo_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       wr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

    always_comb begin
        count_next = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
    end

    // Storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            wr_ready <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count_q  <= count_next;
            wr_ready <= (count_next < CW'(DEPTH));
        end
    end

endmodule

// File: rtl/gearbox_16x2_tx.sv
// Transmit gearbox: buffers 16-bit words in a small FIFO and emits them as
// 2-bit pairs, one pair per cycle in which out_enable is high.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   in_data/in_valid    : word input, accepted when in_ready is high
//   in_ready            : registered, FIFO has room
//   out_enable          : consumer takes the current pair
//   out_data/out_valid  : current pair and its valid flag
//   out_first/out_last  : current pair is pair 0 / pair 7 of its word
//   underrun            : sticky, consumer asked for data while none was live
//   clear_underrun      : clears underrun (a new underrun the same cycle wins)
//   fill_level          : words held in the FIFO, excluding the shifter
module gearbox_16x2_tx
    import gearbox_16x2_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [GB_WORD_W-1:0]         in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         out_enable,
    output logic [GB_PAIR_W-1:0]         out_data,
    output logic                         out_valid,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         underrun,
    input  logic                         clear_underrun,
    output logic [$clog2(FIFO_DEPTH):0]  fill_level
);

    // The live pair always sits at the output end of the shifter.
    localparam int        OUT_LSB    = gb_pair_offset(gb_phase_t'(0), MSB_FIRST);
    localparam gb_phase_t LAST_PHASE = gb_phase_t'(GB_PAIRS - 1);

    logic [GB_WORD_W-1:0] sh;
    logic [GB_WORD_W-1:0] sh_shifted;
    gb_phase_t            phase;
    logic                 sh_valid;
    logic                 armed;
    logic                 underrun_q;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [GB_WORD_W-1:0] fifo_rd_data;

    assign push = in_valid && in_ready;
    // Refill an idle shifter unconditionally; refill a busy one only as its
    // last pair is consumed, so back-to-back words have no gap.
    assign pop  = !fifo_empty && (!sh_valid || (out_enable && phase == LAST_PHASE));

    assign sh_shifted = MSB_FIRST ? (sh << GB_PAIR_W) : (sh >> GB_PAIR_W);

    sync_fifo_reg #(
        .WIDTH (GB_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (push),
        .wr_data  (in_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .count    (fill_level),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .wr_ready (in_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh         <= '0;
            phase      <= '0;
            sh_valid   <= 1'b0;
            armed      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (pop) begin
                sh       <= fifo_rd_data;
                phase    <= '0;
                sh_valid <= 1'b1;
                armed    <= 1'b1;
            end else if (sh_valid && out_enable) begin
                if (phase != LAST_PHASE) begin
                    sh    <= sh_shifted;
                    phase <= phase + gb_phase_t'(1);
                end else begin
                    sh       <= '0;
                    phase    <= '0;
                    sh_valid <= 1'b0;
                end
            end

            // Underrun is only meaningful once traffic has started.
            if (out_enable && !sh_valid && armed) begin
                underrun_q <= 1'b1;
            end else if (clear_underrun) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign out_valid = sh_valid;
    assign out_data  = sh[OUT_LSB +: GB_PAIR_W];
    assign out_first = sh_valid && (phase == '0);
    assign out_last  = sh_valid && (phase == LAST_PHASE);
    assign underrun  = underrun_q;

endmodule
